// File: rtl/lenet_csr_pkg.sv
// Shared definitions for the LeNet control/status slave: register map,
// STATUS/CTRL bit positions and the run-sequencer state encoding.
// No logic; imported by lenet_csr and lenet_run_timer users.
package lenet_csr_pkg;

    // Word addresses on the Avalon-MM slave
    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_IMG_SEL = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_RESULT  = 3'd3;
    localparam logic [2:0] ADDR_CYCLES  = 3'd4;
    localparam logic [2:0] ADDR_TIMEOUT = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EN  = 3'd6;
    localparam logic [2:0] ADDR_RSVD    = 3'd7;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_TERR = 2;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/lenet_run_timer.sv
// Saturating run-cycle counter with clear/enable and timeout compare.
// Latency: count updates one cycle after en; expired is combinational.
// Backpressure: none; counts whenever enabled, sticks at all-ones.
//
// Ports: clk, rst (sync, active-high); clear zeroes the count; en advances
// it; timeout is the compare value (0 disables); count is the current
// value; expired flags the cycle in which the count reaches timeout.
module lenet_run_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] timeout,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] count_inc;

    assign count_inc = (count == '1) ? count : count + CNT_W'(1);

    // Compare against the value being written this cycle, so a timeout of N
    // trips in the N-th enabled cycle and leaves count == N behind.
    assign expired = en && (timeout != '0) && (count_inc == timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/lenet_csr.sv
// Avalon-MM control/status slave for the LeNet core: start/abort, status,
// result capture, run-cycle counter with timeout, optional interrupt.
// Latency: readdata registered (1 cycle); core_start one cycle after start.
// Backpressure: none; always accepts, start while busy is dropped.
//
// Ports: clk/rst (sync active-high); avs_* Avalon-MM slave, read latency 1;
// core_start/core_rst/core_graph drive lenet_top; core_done/core_result
// return the classification; irq is a level interrupt.
// Optional feature: define LENET_CSR_IRQ_EN for the IRQ_EN register and irq.
module lenet_csr
    import lenet_csr_pkg::*;
#(
    parameter int IMG_W       = 5,
    parameter int RES_W       = 4,
    parameter int CNT_W       = 32,
    parameter int DEF_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       avs_address,
    input  logic             avs_chipselect,
    input  logic             avs_write,
    input  logic             avs_read,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             core_start,
    output logic             core_rst,
    output logic [IMG_W-1:0] core_graph,
    input  logic             core_done,
    input  logic [RES_W-1:0] core_result,
    output logic             irq
);

    state_t           state_q, state_d;
    logic [IMG_W-1:0] img_sel;
    logic [RES_W-1:0] result;
    logic [CNT_W-1:0] timeout;
    logic [CNT_W-1:0] cycles;
    logic             done_flag, terr_flag;
    logic             kill_q;
    logic             expired;
    logic             busy;

    logic wr, rd, ctrl_wr, start_req, abort_req, status_wr;
    logic launch, set_done, set_terr, kill;

    assign wr        = avs_chipselect & avs_write;
    assign rd        = avs_chipselect & avs_read;
    assign ctrl_wr   = wr && (avs_address == ADDR_CTRL);
    assign status_wr = wr && (avs_address == ADDR_STATUS);
    // Abort takes precedence when both bits are written together
    assign abort_req = ctrl_wr & avs_writedata[CTRL_ABORT];
    assign start_req = ctrl_wr & avs_writedata[CTRL_START] & ~avs_writedata[CTRL_ABORT];

    assign busy       = (state_q != ST_IDLE);
    assign core_start = (state_q == ST_LAUNCH);
    assign core_graph = img_sel;
    assign core_rst   = rst | kill_q;

    lenet_run_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (launch),
        .en      (state_q == ST_RUN),
        .timeout (timeout),
        .count   (cycles),
        .expired (expired)
    );

    // ---------------- run sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        set_done = 1'b0;
        set_terr = 1'b0;
        kill     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (abort_req) begin
                    kill = 1'b1;
                end else if (start_req) begin
                    state_d = ST_LAUNCH;
                    launch  = 1'b1;
                end
            end
            ST_LAUNCH: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                    kill    = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A software abort outranks completion; completion outranks
                // a timeout expiring in the same cycle.
                if (abort_req) begin
                    state_d = ST_IDLE;
                    kill    = 1'b1;
                end else if (core_done) begin
                    state_d  = ST_IDLE;
                    set_done = 1'b1;
                end else if (expired) begin
                    state_d  = ST_IDLE;
                    set_terr = 1'b1;
                    kill     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done_flag <= 1'b0;
            terr_flag <= 1'b0;
            kill_q    <= 1'b0;
            img_sel   <= '0;
            result    <= '0;
            timeout   <= CNT_W'(DEF_TIMEOUT);
        end else begin
            kill_q <= kill;

            // Sticky flags: a set in the same cycle as a W1C wins
            if (launch) begin
                done_flag <= 1'b0;
                terr_flag <= 1'b0;
            end else begin
                if (set_done) begin
                    done_flag <= 1'b1;
                end else if (status_wr && avs_writedata[STAT_DONE]) begin
                    done_flag <= 1'b0;
                end
                if (set_terr) begin
                    terr_flag <= 1'b1;
                end else if (status_wr && avs_writedata[STAT_TERR]) begin
                    terr_flag <= 1'b0;
                end
            end

            if (set_done) begin
                result <= core_result;
            end

            // Image select is frozen while the core is working on it
            if (wr && (avs_address == ADDR_IMG_SEL) && !busy) begin
                img_sel <= avs_writedata[IMG_W-1:0];
            end

            if (wr && (avs_address == ADDR_TIMEOUT)) begin
                timeout <= avs_writedata[CNT_W-1:0];
            end
        end
    end

`ifdef LENET_CSR_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
        end else if (wr && (avs_address == ADDR_IRQ_EN)) begin
            irq_en <= avs_writedata[0];
        end
    end

    assign irq = irq_en & (done_flag | terr_flag);
`else
    assign irq = 1'b0;
`endif

    // ---------------- read path ----------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL: rd_mux = '0;
            ADDR_IMG_SEL: rd_mux[IMG_W-1:0] = img_sel;
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done_flag;
                rd_mux[STAT_TERR] = terr_flag;
            end
            ADDR_RESULT:  rd_mux[RES_W-1:0] = result;
            ADDR_CYCLES:  rd_mux[CNT_W-1:0] = cycles;
            ADDR_TIMEOUT: rd_mux[CNT_W-1:0] = timeout;
`ifdef LENET_CSR_IRQ_EN
            ADDR_IRQ_EN:  rd_mux[0] = irq_en;
`else
            ADDR_IRQ_EN:  rd_mux = '0;
`endif
            ADDR_RSVD:    rd_mux = '0;
            default:      rd_mux = '0;
        endcase
    end

    // Sampling the current state here gives reads the pre-change value
    always_ff @(posedge clk) begin
        if (rst) begin
            avs_readdata <= '0;
        end else begin
            avs_readdata <= rd ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_lenet_csr.sv
// Directed bench for lenet_csr: register map, run completion, timeout,
// busy write protection, abort, done-vs-timeout priority, irq, mid-run reset.
module tb_lenet_csr;

    localparam int IMG_W  = 5;
    localparam int RES_W  = 4;
    localparam int CNT_W  = 32;
    localparam int DEF_TO = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       avs_address;
    logic             avs_chipselect, avs_write, avs_read;
    logic [31:0]      avs_writedata;
    logic [31:0]      avs_readdata;
    logic             core_start, core_rst;
    logic [IMG_W-1:0] core_graph;
    logic             core_done;
    logic [RES_W-1:0] core_result;
    logic             irq;

    lenet_csr #(
        .IMG_W(IMG_W), .RES_W(RES_W), .CNT_W(CNT_W), .DEF_TIMEOUT(DEF_TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .avs_address    (avs_address),
        .avs_chipselect (avs_chipselect),
        .avs_write      (avs_write),
        .avs_read       (avs_read),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .core_start     (core_start),
        .core_rst       (core_rst),
        .core_graph     (core_graph),
        .core_done      (core_done),
        .core_result    (core_result),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse/stability monitors, sampled on the falling edge
    int          start_cnt = 0;
    int          rstp_cnt  = 0;
    int          graph_err = 0;
    logic        graph_watch = 1'b0;
    logic [IMG_W-1:0] graph_exp = '0;

    always @(negedge clk) begin
        if (core_start) start_cnt++;
        if (core_rst && !rst) rstp_cnt++;
        if (graph_watch && core_graph !== graph_exp) graph_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address    = a;
        avs_writedata  = d;
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        tick(1);
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_address    = a;
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        tick(1);
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        d = avs_readdata;
    endtask

    task automatic pulse_done(input logic [RES_W-1:0] r);
        core_done   = 1'b1;
        core_result = r;
        tick(1);
        core_done   = 1'b0;
        core_result = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rdat;

    initial begin
        rst = 1'b1;
        avs_address = '0; avs_chipselect = 1'b0; avs_write = 1'b0;
        avs_read = 1'b0; avs_writedata = '0;
        core_done = 1'b0; core_result = '0;
        tick(3);
        chk("rst_core_rst_high", {31'd0, core_rst}, 32'd1);
        rst = 1'b0;
        tick(1);

        // ---- reset state and full map readback ----
        chk("rst_core_rst_low", {31'd0, core_rst}, 32'd0);
        chk("rst_core_start", {31'd0, core_start}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_graph", {27'd0, core_graph}, 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rdat);
            chk($sformatf("rst_read_addr%0d", a), rdat, (a == 5) ? DEF_TO : 32'd0);
        end

        // ---- normal run: result 9 after 7 RUN cycles ----
        bus_write(3'd1, 32'h13);
        bus_read(3'd1, rdat);
        chk("img_sel_rb", rdat, 32'h13);
        start_cnt = 0; graph_exp = 5'h13; graph_watch = 1'b1;
        bus_write(3'd0, 32'h1);                 // now in LAUNCH
        chk("launch_start_pulse", {31'd0, core_start}, 32'd1);
        tick(1);                                // RUN cycle 1
        bus_read(3'd2, rdat);                   // now RUN cycle 2
        chk("run_status_busy", rdat, 32'b001);
        tick(5);                                // RUN cycle 7
        pulse_done(4'd9);
        bus_read(3'd2, rdat);
        chk("run_status_done", rdat, 32'b010);
        bus_read(3'd3, rdat);
        chk("run_result", rdat, 32'd9);
        bus_read(3'd4, rdat);
        chk("run_cycles", rdat, 32'd7);
        chk("run_start_count", start_cnt, 32'd1);
        graph_watch = 1'b0;
        chk("run_graph_stable", graph_err, 32'd0);

        // ---- timeout after 10 RUN cycles ----
        bus_write(3'd5, 32'd10);
        bus_read(3'd5, rdat);
        chk("timeout_rb", rdat, 32'd10);
        rstp_cnt = 0;
        bus_write(3'd0, 32'h1);                 // LAUNCH
        tick(10);                               // RUN cycle 10
        chk("to_no_rst_yet", {31'd0, core_rst}, 32'd0);
        tick(1);                                // back in IDLE
        chk("to_core_rst_pulse", {31'd0, core_rst}, 32'd1);
        bus_read(3'd2, rdat);
        chk("to_status", rdat, 32'b100);
        bus_read(3'd4, rdat);
        chk("to_cycles", rdat, 32'd10);
        chk("to_rst_count", rstp_cnt, 32'd1);
        bus_write(3'd2, 32'b100);               // W1C timeout_err
        bus_read(3'd2, rdat);
        chk("to_w1c", rdat, 32'd0);
        bus_write(3'd5, 32'd0);

        // ---- writes while busy are ignored ----
        start_cnt = 0; graph_exp = 5'h13; graph_watch = 1'b1;
        bus_write(3'd0, 32'h1);                 // LAUNCH
        tick(1);                                // RUN 1
        bus_write(3'd1, 32'h2);                 // -> RUN 2
        bus_write(3'd0, 32'h1);                 // -> RUN 3
        bus_read(3'd1, rdat);                   // -> RUN 4
        chk("busy_img_ignored", rdat, 32'h13);
        pulse_done(4'd5);
        graph_watch = 1'b0;
        chk("busy_graph_stable", graph_err, 32'd0);
        chk("busy_single_start", start_cnt, 32'd1);
        bus_read(3'd3, rdat);
        chk("busy_result", rdat, 32'd5);
        bus_read(3'd4, rdat);
        chk("busy_cycles", rdat, 32'd4);

        // ---- abort at RUN cycle 3 ----
        rstp_cnt = 0;
        bus_write(3'd0, 32'h1);                 // LAUNCH
        tick(3);                                // RUN 3
        bus_write(3'd0, 32'h2);                 // abort -> IDLE
        chk("abort_core_rst", {31'd0, core_rst}, 32'd1);
        bus_read(3'd2, rdat);
        chk("abort_status", rdat, 32'd0);
        pulse_done(4'hF);                       // stray completion
        bus_read(3'd2, rdat);
        chk("abort_stray_status", rdat, 32'd0);
        bus_read(3'd3, rdat);
        chk("abort_stray_result", rdat, 32'd5);
        chk("abort_rst_count", rstp_cnt, 32'd1);

        // ---- start and abort together: abort wins ----
        start_cnt = 0;
        bus_write(3'd0, 32'h3);
        chk("both_core_rst", {31'd0, core_rst}, 32'd1);
        chk("both_no_start", {31'd0, core_start}, 32'd0);
        bus_read(3'd2, rdat);
        chk("both_status_idle", rdat, 32'd0);
        chk("both_start_count", start_cnt, 32'd0);

        // ---- done coincident with timeout expiry: done wins ----
        bus_write(3'd5, 32'd3);
        bus_write(3'd0, 32'h1);                 // LAUNCH
        tick(3);                                // RUN 3
        pulse_done(4'd6);
        bus_read(3'd2, rdat);
        chk("tie_status", rdat, 32'b010);
        bus_read(3'd3, rdat);
        chk("tie_result", rdat, 32'd6);
        bus_read(3'd4, rdat);
        chk("tie_cycles", rdat, 32'd3);

        // ---- interrupt ----
`ifdef LENET_CSR_IRQ_EN
        bus_write(3'd6, 32'h1);
        bus_read(3'd6, rdat);
        chk("irq_en_rb", rdat, 32'd1);
        chk("irq_asserted", {31'd0, irq}, 32'd1);
        bus_write(3'd2, 32'b010);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
`else
        bus_write(3'd6, 32'h1);
        bus_read(3'd6, rdat);
        chk("irq_en_absent", rdat, 32'd0);
        chk("irq_tied_low", {31'd0, irq}, 32'd0);
`endif

        // ---- reset in the middle of a run ----
        bus_write(3'd1, 32'h0A);
        bus_write(3'd0, 32'h1);                 // LAUNCH
        tick(2);                                // RUN 2
        rst = 1'b1;
        tick(1);
        chk("midrst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("midrst_no_start", {31'd0, core_start}, 32'd0);
        rst = 1'b0;
        tick(1);
        bus_read(3'd2, rdat);
        chk("midrst_status", rdat, 32'd0);
        bus_read(3'd4, rdat);
        chk("midrst_cycles", rdat, 32'd0);
        bus_read(3'd5, rdat);
        chk("midrst_timeout", rdat, DEF_TO);
        bus_read(3'd1, rdat);
        chk("midrst_img_sel", rdat, 32'd0);
        bus_read(3'd3, rdat);
        chk("midrst_result", rdat, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
